br_resolve_ctrl: RTL and testbench
==================================

// Module: br_resolve_ctrl
// PURPOSE
//  Sequencer between the EX issue stage and the combinational branch unit. Accepts one
//  branch/jump at a time, waits for forwarded operands, fires the branch unit for one cycle,
//  then issues a fetch redirect with a younger-instruction kill and a link-register write.
//  A flush from an older instruction aborts it. Also keeps branch/taken performance counters.
// PARAMETERS
//  GRLEN      32  datapath width; also the width of PC, operand, target and counter
//  OP_W       `LSOC1K_BRU_CODE_BIT  branch opcode width
//  RD_W       5   destination register index width
// PORTS
//  clk              in   1      clock
//  resetn           in   1      reset; synchronous, active-low
//  ex_br_valid      in   1      branch offered by EX
//  ex_br_ready      out  1      controller can accept a branch
//  ex_br_op         in   OP_W   BRU opcode (shared decode codes)
//  ex_br_pc         in   GRLEN  branch PC
//  ex_br_offset     in   GRLEN  sign-extended offset
//  ex_br_rd         in   RD_W   link destination
//  ex_br_a/ex_br_b  in   GRLEN  forwarded operands, sampled when ex_opnd_rdy=1
//  ex_opnd_rdy      in   1      operands on ex_br_a/b are final
//  flush            in   1      older-instruction flush; highest priority
//  bru_valid        out  1      fire the branch unit
//  bru_op/bru_pc/bru_offset/bru_a/bru_b  out  OP_W/GRLEN x4  registered branch-unit inputs
//  bru_taken        in   1      branch-unit result (already qualified by bru_valid)
//  bru_target       in   GRLEN  branch-unit target
//  bru_link_pc      in   GRLEN  PC+4
//  bru_wen          in   1      link write required (BL/JIRL)
//  fe_redir_valid   out  1      redirect request to fetch
//  fe_redir_target  out  GRLEN  redirect PC
//  fe_redir_ack     in   1      fetch accepted the redirect
//  kill_younger     out  1      one-cycle pulse: squash younger in-flight instructions
//  wb_req           out  1      link write request to the regfile write-port arbiter
//  wb_rd            out  RD_W   link register index
//  wb_data          out  GRLEN  link value
//  wb_gnt           in   1      write port granted; the write happens this cycle
//  busy             out  1      state != IDLE
//  perf_br_cnt      out  GRLEN  branches resolved
//  perf_taken_cnt   out  GRLEN  taken branches resolved
// BEHAVIOUR
//  States: IDLE, WAIT_OPND, RESOLVE, REDIRECT, LINK_WB. Registered; outputs decoded from state.
//  Reset (resetn=0 at posedge): state=IDLE, all regs and counters 0.
//    While resetn=0, every output is 0, including ex_br_ready.
//  IDLE: ex_br_ready=1. Accept = valid & ready & !flush. On accept, latch op/pc/offset/rd.
//    If ex_opnd_rdy=1 in the same cycle, also latch a/b and go to RESOLVE; else go to WAIT_OPND.
//  WAIT_OPND: on ex_opnd_rdy=1, latch a/b and go to RESOLVE.
//  RESOLVE: exactly 1 cycle with bru_valid=1. At the clock edge, latch taken/target/link_pc/wen.
//    Increment perf_br_cnt; if taken, also increment perf_taken_cnt.
//    Next state: taken -> REDIRECT; !taken & wen -> LINK_WB; otherwise -> IDLE.
//  REDIRECT: fe_redir_valid=1, target stable until acked.
//    kill_younger=1 only in the first REDIRECT cycle.
//    On ack: wen & rd!=0 -> LINK_WB; otherwise -> IDLE.
//  LINK_WB: wb_req=1 with wb_rd/wb_data=link_pc held until wb_gnt, then -> IDLE.
//    rd==0 never enters LINK_WB.
//  Latency: accept to redirect = 2 cycles with operands ready.
//    Minimum spacing between not-taken, non-link branches = 2 cycles (ready only in IDLE).
//  flush=1 in any state: next state IDLE; flush beats accept, opnd_rdy, ack and gnt in the same cycle.
//    Pending redirect/write dropped; outputs 0 next cycle.
//    A flush during RESOLVE does not update the counters.
//  Counters: GRLEN-bit, wrap from all-ones to 0, no saturation.
// STRUCTURE
//  Shared package/header: state encoding localparams and BRU op codes (existing decode header).
//    No new typedefs.
//  One sub-module: br_perf_cnt, a pair of wrapping counters with an enable per counter.
//  The branch unit is instantiated by the parent, not inside this block.
// TESTING
//  BEQ a=b=5 at pc=0x100, offset 0x20, opnd_rdy at accept.
//    -> bru_valid 1 cycle after accept; redirect to 0x120 and kill pulse the next cycle; no wb_req.
//  BNE a=b=5, opnd_rdy held 0 for 3 cycles. -> WAIT_OPND 3 cycles; no redirect; IDLE;
//    perf_br_cnt+1, perf_taken_cnt+0.
//  JIRL rd=1, a=0x2000, pc=0x40, offset 8, fe_redir_ack delayed 2 cycles.
//    -> target 0x2008 held stable; kill pulses once; then wb_req rd=1 data=0x44 until wb_gnt.
//  BL rd=0. -> redirect only, then IDLE; wb_req never asserts.
//  flush in WAIT_OPND, in REDIRECT together with ack, and in LINK_WB together with gnt.
//    -> IDLE next cycle in each case; all outputs 0; no write; counters unchanged.
//  Preload perf_taken_cnt to 0xFFFFFFFF via force, then one taken branch. -> count reads 0.
//    Also: resetn low mid-REDIRECT -> all outputs 0 and IDLE after the edge.

Source files
------------

// File: rtl/br_resolve_ctrl_pkg.sv
// Shared definitions for the branch-resolve sequencer.
//  - BRU opcode codes, mirroring the existing decode header (code width BRU_CODE_BIT).
//  - State encoding of the sequencer FSM as plain localparams.
package br_resolve_ctrl_pkg;

  // Branch-unit opcode width and codes, shared with the decode stage.
  localparam int BRU_CODE_BIT = 4;

  localparam logic [BRU_CODE_BIT-1:0] BRU_NOP  = 4'd0;
  localparam logic [BRU_CODE_BIT-1:0] BRU_BEQ  = 4'd1;
  localparam logic [BRU_CODE_BIT-1:0] BRU_BNE  = 4'd2;
  localparam logic [BRU_CODE_BIT-1:0] BRU_BLT  = 4'd3;
  localparam logic [BRU_CODE_BIT-1:0] BRU_BGE  = 4'd4;
  localparam logic [BRU_CODE_BIT-1:0] BRU_BLTU = 4'd5;
  localparam logic [BRU_CODE_BIT-1:0] BRU_BGEU = 4'd6;
  localparam logic [BRU_CODE_BIT-1:0] BRU_B    = 4'd7;
  localparam logic [BRU_CODE_BIT-1:0] BRU_BL   = 4'd8;
  localparam logic [BRU_CODE_BIT-1:0] BRU_JIRL = 4'd9;

  // Sequencer state encoding.
  localparam int ST_W = 3;

  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_WAIT_OPND = 3'd1;
  localparam logic [ST_W-1:0] ST_RESOLVE   = 3'd2;
  localparam logic [ST_W-1:0] ST_REDIRECT  = 3'd3;
  localparam logic [ST_W-1:0] ST_LINK_WB   = 3'd4;

endpackage

// File: rtl/br_resolve_ctrl_perf.sv
// br_perf_cnt: pair of free-running wrapping event counters.
//  clk           in   clock
//  resetn        in   synchronous active-low reset, clears both counters
//  inc_br_i      in   count one resolved branch this cycle
//  inc_taken_i   in   count one taken branch this cycle
//  br_cnt_o      out  resolved-branch count
//  taken_cnt_o   out  taken-branch count
// Counters wrap from all-ones to zero; there is no saturation.
module br_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc_br_i,
  input  logic         inc_taken_i,
  output logic [W-1:0] br_cnt_o,
  output logic [W-1:0] taken_cnt_o
);

  logic [W-1:0] br_cnt_q;
  logic [W-1:0] br_cnt_d;
  logic [W-1:0] taken_cnt_q;
  logic [W-1:0] taken_cnt_d;

  // Registers load every cycle; the increment is zero when the enable is low,
  // so the natural binary overflow gives the wrap behaviour.
  always_comb begin
    br_cnt_d    = br_cnt_q + {{(W-1){1'b0}}, inc_br_i};
    taken_cnt_d = taken_cnt_q + {{(W-1){1'b0}}, inc_taken_i};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      br_cnt_q    <= '0;
      taken_cnt_q <= '0;
    end else begin
      br_cnt_q    <= br_cnt_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign br_cnt_o    = br_cnt_q;
  assign taken_cnt_o = taken_cnt_q;

endmodule

// File: rtl/br_resolve_ctrl.sv
// br_resolve_ctrl: sequencer between EX issue and the combinational branch unit.
//  Accepts one branch/jump at a time, waits for forwarded operands, fires the
//  branch unit for one cycle, then issues a fetch redirect (with a one-cycle
//  younger-instruction kill) and/or a link-register write. An older-instruction
//  flush aborts whatever is in flight. Keeps resolved/taken performance counters.
// Ports:
//  clk, resetn                  clock, synchronous active-low reset
//  ex_br_valid/ex_br_ready      branch handshake from EX
//  ex_br_op/pc/offset/rd        branch descriptor, latched on accept
//  ex_br_a/ex_br_b, ex_opnd_rdy forwarded operands, latched when ready
//  flush                        older-instruction flush, highest priority
//  bru_valid, bru_op/pc/offset/a/b   registered branch-unit inputs
//  bru_taken/target/link_pc/wen      branch-unit results
//  fe_redir_valid/target/ack    fetch redirect request
//  kill_younger                 one-cycle squash pulse
//  wb_req/rd/data, wb_gnt       link write request to the write-port arbiter
//  busy                         sequencer not idle
//  perf_br_cnt/perf_taken_cnt   performance counters
module br_resolve_ctrl
  import br_resolve_ctrl_pkg::*;
#(
  parameter int GRLEN = 32,
  parameter int OP_W  = BRU_CODE_BIT,
  parameter int RD_W  = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ex_br_valid,
  output logic             ex_br_ready,
  input  logic [OP_W-1:0]  ex_br_op,
  input  logic [GRLEN-1:0] ex_br_pc,
  input  logic [GRLEN-1:0] ex_br_offset,
  input  logic [RD_W-1:0]  ex_br_rd,
  input  logic [GRLEN-1:0] ex_br_a,
  input  logic [GRLEN-1:0] ex_br_b,
  input  logic             ex_opnd_rdy,
  input  logic             flush,
  output logic             bru_valid,
  output logic [OP_W-1:0]  bru_op,
  output logic [GRLEN-1:0] bru_pc,
  output logic [GRLEN-1:0] bru_offset,
  output logic [GRLEN-1:0] bru_a,
  output logic [GRLEN-1:0] bru_b,
  input  logic             bru_taken,
  input  logic [GRLEN-1:0] bru_target,
  input  logic [GRLEN-1:0] bru_link_pc,
  input  logic             bru_wen,
  output logic             fe_redir_valid,
  output logic [GRLEN-1:0] fe_redir_target,
  input  logic             fe_redir_ack,
  output logic             kill_younger,
  output logic             wb_req,
  output logic [RD_W-1:0]  wb_rd,
  output logic [GRLEN-1:0] wb_data,
  input  logic             wb_gnt,
  output logic             busy,
  output logic [GRLEN-1:0] perf_br_cnt,
  output logic [GRLEN-1:0] perf_taken_cnt
);

  logic [ST_W-1:0]  state_q;
  logic [ST_W-1:0]  state_d;
  logic             kill_q;
  logic             kill_d;

  // Branch descriptor and operands.
  logic [OP_W-1:0]  op_q;
  logic [GRLEN-1:0] pc_q;
  logic [GRLEN-1:0] off_q;
  logic [RD_W-1:0]  rd_q;
  logic [GRLEN-1:0] a_q;
  logic [GRLEN-1:0] b_q;

  // Branch-unit results captured at the end of RESOLVE.
  logic [GRLEN-1:0] target_q;
  logic [GRLEN-1:0] link_q;
  logic             wen_q;

  logic             accept;
  logic             opnd_take;
  logic             resolve_done;
  logic             rd_nonzero;
  logic [GRLEN-1:0] br_cnt;
  logic [GRLEN-1:0] taken_cnt;

  // flush wins over every handshake in the same cycle.
  assign accept       = (state_q == ST_IDLE) && ex_br_valid && !flush;
  assign opnd_take    = (state_q == ST_WAIT_OPND) && ex_opnd_rdy && !flush;
  assign resolve_done = (state_q == ST_RESOLVE) && !flush;
  assign rd_nonzero   = (rd_q != '0);

  // ---------------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      kill_q   <= 1'b0;
      op_q     <= '0;
      pc_q     <= '0;
      off_q    <= '0;
      rd_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      target_q <= '0;
      link_q   <= '0;
      wen_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (accept) begin
        op_q  <= ex_br_op;
        pc_q  <= ex_br_pc;
        off_q <= ex_br_offset;
        rd_q  <= ex_br_rd;
      end
      if ((accept && ex_opnd_rdy) || opnd_take) begin
        a_q <= ex_br_a;
        b_q <= ex_br_b;
      end
      if (resolve_done) begin
        target_q <= bru_target;
        link_q   <= bru_link_pc;
        wen_q    <= bru_wen;
      end
    end
  end

  // ---------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ex_opnd_rdy ? ST_RESOLVE : ST_WAIT_OPND;
      end
      ST_WAIT_OPND: begin
        if (ex_opnd_rdy) state_d = ST_RESOLVE;
      end
      ST_RESOLVE: begin
        // A link write to r0 is discarded, so it never reaches LINK_WB.
        if (bru_taken)                     state_d = ST_REDIRECT;
        else if (bru_wen && rd_nonzero)    state_d = ST_LINK_WB;
        else                               state_d = ST_IDLE;
      end
      ST_REDIRECT: begin
        if (fe_redir_ack) state_d = (wen_q && rd_nonzero) ? ST_LINK_WB : ST_IDLE;
      end
      ST_LINK_WB: begin
        if (wb_gnt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Kill is armed only on the transition into REDIRECT, so a redirect that
  // waits several cycles for its ack still squashes exactly once.
  assign kill_d = (state_d == ST_REDIRECT) && (state_q != ST_REDIRECT);

  // ---------------------------------------------------------------- outputs
  // Everything is qualified by resetn so outputs read zero while reset is held,
  // even before the first clock edge has cleared the registers.
  always_comb begin
    ex_br_ready     = 1'b0;
    bru_valid       = 1'b0;
    bru_op          = '0;
    bru_pc          = '0;
    bru_offset      = '0;
    bru_a           = '0;
    bru_b           = '0;
    fe_redir_valid  = 1'b0;
    fe_redir_target = '0;
    kill_younger    = 1'b0;
    wb_req          = 1'b0;
    wb_rd           = '0;
    wb_data         = '0;
    busy            = 1'b0;
    perf_br_cnt     = '0;
    perf_taken_cnt  = '0;
    if (resetn) begin
      busy           = (state_q != ST_IDLE);
      perf_br_cnt    = br_cnt;
      perf_taken_cnt = taken_cnt;
      unique case (state_q)
        ST_IDLE: begin
          ex_br_ready = 1'b1;
        end
        ST_RESOLVE: begin
          bru_valid  = 1'b1;
          bru_op     = op_q;
          bru_pc     = pc_q;
          bru_offset = off_q;
          bru_a      = a_q;
          bru_b      = b_q;
        end
        ST_REDIRECT: begin
          fe_redir_valid  = 1'b1;
          fe_redir_target = target_q;
          kill_younger    = kill_q;
        end
        ST_LINK_WB: begin
          wb_req  = 1'b1;
          wb_rd   = rd_q;
          wb_data = link_q;
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- counters
  // A flushed RESOLVE never completes, so it is not counted.
  br_perf_cnt #(
    .W (GRLEN)
  ) u_perf (
    .clk         (clk),
    .resetn      (resetn),
    .inc_br_i    (resolve_done),
    .inc_taken_i (resolve_done && bru_taken),
    .br_cnt_o    (br_cnt),
    .taken_cnt_o (taken_cnt)
  );

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Directed bench for br_resolve_ctrl: a table of per-cycle stimulus and
// expected outputs, followed by hand-written counter-wrap and reset sequences.
// The bench also plays the branch unit, computing results from bru_* outputs.
module tb_br_resolve_ctrl;
  import br_resolve_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ex_br_valid;
  logic        ex_br_ready;
  logic [3:0]  ex_br_op;
  logic [31:0] ex_br_pc, ex_br_offset, ex_br_a, ex_br_b;
  logic [4:0]  ex_br_rd;
  logic        ex_opnd_rdy, flush;
  logic        bru_valid;
  logic [3:0]  bru_op;
  logic [31:0] bru_pc, bru_offset, bru_a, bru_b;
  logic        bru_taken, bru_wen;
  logic [31:0] bru_target, bru_link_pc;
  logic        fe_redir_valid, fe_redir_ack, kill_younger;
  logic [31:0] fe_redir_target;
  logic        wb_req, wb_gnt, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, perf_br_cnt, perf_taken_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  br_resolve_ctrl #(.GRLEN(32), .OP_W(4), .RD_W(5)) dut (
    .clk(clk), .resetn(resetn),
    .ex_br_valid(ex_br_valid), .ex_br_ready(ex_br_ready), .ex_br_op(ex_br_op),
    .ex_br_pc(ex_br_pc), .ex_br_offset(ex_br_offset), .ex_br_rd(ex_br_rd),
    .ex_br_a(ex_br_a), .ex_br_b(ex_br_b), .ex_opnd_rdy(ex_opnd_rdy), .flush(flush),
    .bru_valid(bru_valid), .bru_op(bru_op), .bru_pc(bru_pc), .bru_offset(bru_offset),
    .bru_a(bru_a), .bru_b(bru_b), .bru_taken(bru_taken), .bru_target(bru_target),
    .bru_link_pc(bru_link_pc), .bru_wen(bru_wen),
    .fe_redir_valid(fe_redir_valid), .fe_redir_target(fe_redir_target),
    .fe_redir_ack(fe_redir_ack), .kill_younger(kill_younger),
    .wb_req(wb_req), .wb_rd(wb_rd), .wb_data(wb_data), .wb_gnt(wb_gnt),
    .busy(busy), .perf_br_cnt(perf_br_cnt), .perf_taken_cnt(perf_taken_cnt)
  );

  // Behavioural branch unit (subset of ops used here).
  always_comb begin
    bru_taken   = 1'b0;
    bru_wen     = 1'b0;
    bru_target  = 32'h0;
    bru_link_pc = 32'h0;
    if (bru_valid) begin
      bru_link_pc = bru_pc + 32'd4;
      bru_target  = (bru_op == BRU_JIRL) ? bru_a + bru_offset : bru_pc + bru_offset;
      case (bru_op)
        BRU_BEQ:  bru_taken = (bru_a == bru_b);
        BRU_BNE:  bru_taken = (bru_a != bru_b);
        BRU_B:    bru_taken = 1'b1;
        BRU_BL:   begin bru_taken = 1'b1; bru_wen = 1'b1; end
        BRU_JIRL: begin bru_taken = 1'b1; bru_wen = 1'b1; end
        default:  bru_taken = 1'b0;
      endcase
    end
  end

  // Expected flag groups: {ready, bru_valid, redir_valid, kill, wb_req, busy}
  localparam logic [5:0] F_IDLE = 6'b100000;
  localparam logic [5:0] F_WAIT = 6'b000001;
  localparam logic [5:0] F_RES  = 6'b010001;
  localparam logic [5:0] F_REDK = 6'b001101;
  localparam logic [5:0] F_RED  = 6'b001001;
  localparam logic [5:0] F_WB   = 6'b000011;

  typedef struct {
    string       nm;
    logic        v;
    logic [3:0]  op;
    logic [31:0] pc, off;
    logic [4:0]  rd;
    logic [31:0] a, b;
    logic        ordy, fl, ack, gnt;
    logic [5:0]  flags;
    logic [31:0] tgt;
    logic [4:0]  wrd;
    logic [31:0] wdat, nbr, ntk;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string nm, input logic v, input logic [3:0] op,
                     input logic [31:0] pc, input logic [31:0] off, input logic [4:0] rd,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic ordy, input logic fl, input logic ack, input logic gnt,
                     input logic [5:0] flags, input logic [31:0] tgt, input logic [4:0] wrd,
                     input logic [31:0] wdat, input logic [31:0] nbr, input logic [31:0] ntk);
    vec_t t;
    t.nm = nm; t.v = v; t.op = op; t.pc = pc; t.off = off; t.rd = rd; t.a = a; t.b = b;
    t.ordy = ordy; t.fl = fl; t.ack = ack; t.gnt = gnt; t.flags = flags; t.tgt = tgt;
    t.wrd = wrd; t.wdat = wdat; t.nbr = nbr; t.ntk = ntk;
    vq.push_back(t);
  endtask

  // Cycle with no branch offered.
  task automatic nop(input string nm, input logic ordy, input logic [31:0] a, input logic [31:0] b,
                     input logic fl, input logic ack, input logic gnt,
                     input logic [5:0] flags, input logic [31:0] tgt, input logic [4:0] wrd,
                     input logic [31:0] wdat, input logic [31:0] nbr, input logic [31:0] ntk);
    add(nm, 1'b0, 4'd0, 32'h0, 32'h0, 5'd0, a, b, ordy, fl, ack, gnt, flags, tgt, wrd, wdat, nbr, ntk);
  endtask

  task automatic set_in(input logic v, input logic [3:0] op, input logic [31:0] pc,
                        input logic [31:0] off, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic ordy, input logic fl,
                        input logic ack, input logic gnt);
    ex_br_valid = v; ex_br_op = op; ex_br_pc = pc; ex_br_offset = off; ex_br_rd = rd;
    ex_br_a = a; ex_br_b = b; ex_opnd_rdy = ordy; flush = fl; fe_redir_ack = ack; wb_gnt = gnt;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [74:0] main_outs();
    return {ex_br_ready, bru_valid, fe_redir_valid, kill_younger, wb_req, busy,
            fe_redir_target, wb_rd, wb_data};
  endfunction

  function automatic logic [270:0] all_outs();
    return {ex_br_ready, bru_valid, bru_op, bru_pc, bru_offset, bru_a, bru_b,
            fe_redir_valid, fe_redir_target, kill_younger, wb_req, wb_rd, wb_data,
            busy, perf_br_cnt, perf_taken_cnt};
  endfunction

  initial begin
    resetn = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("reset_pre_edge", 320'(all_outs()), 320'h0);
    repeat (3) tick();
    chk("reset_hold", 320'(all_outs()), 320'h0);

    // ---- per-cycle table: inputs applied this cycle, outputs expected this cycle
    // BEQ taken, operands ready at accept, ack one cycle after redirect.
    add("beq_acc", 1, BRU_BEQ, 32'h100, 32'h20, 0, 5, 5, 1, 0, 0, 0, F_IDLE, 0, 0, 0, 0, 0);
    nop("beq_res",   0, 0, 0, 0, 0, 0, F_RES,  0,      0, 0, 0, 0);
    nop("beq_redir", 0, 0, 0, 0, 0, 0, F_REDK, 32'h120, 0, 0, 1, 1);
    nop("beq_ack",   0, 0, 0, 0, 1, 0, F_RED,  32'h120, 0, 0, 1, 1);
    // BNE not taken; stale operands at accept, final ones after 3 WAIT cycles.
    add("bne_acc", 1, BRU_BNE, 32'h200, 32'h10, 0, 9, 3, 0, 0, 0, 0, F_IDLE, 0, 0, 0, 1, 1);
    nop("bne_wait1", 0, 0, 0, 0, 0, 0, F_WAIT, 0, 0, 0, 1, 1);
    nop("bne_wait2", 0, 0, 0, 0, 0, 0, F_WAIT, 0, 0, 0, 1, 1);
    nop("bne_wait3", 1, 5, 5, 0, 0, 0, F_WAIT, 0, 0, 0, 1, 1);
    nop("bne_res",   0, 0, 0, 0, 0, 0, F_RES,  0, 0, 0, 1, 1);
    // JIRL rd=1, ack two cycles late, then link write with grant one cycle late.
    add("jirl_acc", 1, BRU_JIRL, 32'h40, 32'h8, 1, 32'h2000, 0, 1, 0, 0, 0, F_IDLE, 0, 0, 0, 2, 1);
    nop("jirl_res",   0, 0, 0, 0, 0, 0, F_RES,  0,        0, 0,     2, 1);
    nop("jirl_redk",  0, 0, 0, 0, 0, 0, F_REDK, 32'h2008, 0, 0,     3, 2);
    nop("jirl_hold1", 0, 0, 0, 0, 0, 0, F_RED,  32'h2008, 0, 0,     3, 2);
    nop("jirl_ack",   0, 0, 0, 0, 1, 0, F_RED,  32'h2008, 0, 0,     3, 2);
    nop("jirl_wb1",   0, 0, 0, 0, 0, 0, F_WB,   0,        1, 32'h44, 3, 2);
    nop("jirl_wbgnt", 0, 0, 0, 0, 0, 1, F_WB,   0,        1, 32'h44, 3, 2);
    // BL to r0: redirect only.
    add("bl0_acc", 1, BRU_BL, 32'h300, 32'h40, 0, 0, 0, 1, 0, 0, 0, F_IDLE, 0, 0, 0, 3, 2);
    nop("bl0_res",  0, 0, 0, 0, 0, 0, F_RES,  0,       0, 0, 3, 2);
    nop("bl0_redk", 0, 0, 0, 0, 0, 0, F_REDK, 32'h340, 0, 0, 4, 3);
    nop("bl0_ack",  0, 0, 0, 0, 1, 0, F_RED,  32'h340, 0, 0, 4, 3);
    // Back-to-back not-taken branches, two cycles apart.
    add("nt1_acc", 1, BRU_BEQ, 32'h400, 32'h10, 0, 1, 2, 1, 0, 0, 0, F_IDLE, 0, 0, 0, 4, 3);
    nop("nt1_res", 0, 0, 0, 0, 0, 0, F_RES, 0, 0, 0, 4, 3);
    add("nt2_acc", 1, BRU_BNE, 32'h410, 32'h10, 0, 3, 3, 1, 0, 0, 0, F_IDLE, 0, 0, 0, 5, 3);
    nop("nt2_res", 0, 0, 0, 0, 0, 0, F_RES, 0, 0, 0, 5, 3);
    // Flush in WAIT_OPND, colliding with operands becoming ready.
    add("fw_acc", 1, BRU_BEQ, 32'h500, 32'h10, 0, 0, 0, 0, 0, 0, 0, F_IDLE, 0, 0, 0, 6, 3);
    nop("fw_flush", 1, 4, 4, 1, 0, 0, F_WAIT, 0, 0, 0, 6, 3);
    // Flush in REDIRECT together with ack: pending link write dropped.
    add("fr_acc", 1, BRU_JIRL, 32'h600, 32'h4, 2, 32'h3000, 0, 1, 0, 0, 0, F_IDLE, 0, 0, 0, 6, 3);
    nop("fr_res",   0, 0, 0, 0, 0, 0, F_RES,  0,        0, 0, 6, 3);
    nop("fr_redk",  0, 0, 0, 0, 0, 0, F_REDK, 32'h3004, 0, 0, 7, 4);
    nop("fr_flush", 0, 0, 0, 1, 1, 0, F_RED,  32'h3004, 0, 0, 7, 4);
    // Flush in LINK_WB together with gnt.
    add("fl_acc", 1, BRU_BL, 32'h700, 32'h8, 3, 0, 0, 1, 0, 0, 0, F_IDLE, 0, 0, 0, 7, 4);
    nop("fl_res",   0, 0, 0, 0, 0, 0, F_RES,  0,       0, 0,      7, 4);
    nop("fl_redk",  0, 0, 0, 0, 0, 0, F_REDK, 32'h708, 0, 0,      8, 5);
    nop("fl_ack",   0, 0, 0, 0, 1, 0, F_RED,  32'h708, 0, 0,      8, 5);
    nop("fl_flush", 0, 0, 0, 1, 0, 1, F_WB,   0,       3, 32'h704, 8, 5);
    // Flush in RESOLVE: counters must not move.
    add("fs_acc", 1, BRU_BEQ, 32'h800, 32'h10, 0, 7, 7, 1, 0, 0, 0, F_IDLE, 0, 0, 0, 8, 5);
    nop("fs_flush", 0, 0, 0, 1, 0, 0, F_RES, 0, 0, 0, 8, 5);
    // Flush beats accept in IDLE.
    add("fa_acc", 1, BRU_BEQ, 32'h900, 32'h10, 0, 1, 1, 1, 1, 0, 0, F_IDLE, 0, 0, 0, 8, 5);
    nop("fa_idle", 0, 0, 0, 0, 0, 0, F_IDLE, 0, 0, 0, 8, 5);

    resetn = 1'b1;
    foreach (vq[i]) begin
      set_in(vq[i].v, vq[i].op, vq[i].pc, vq[i].off, vq[i].rd, vq[i].a, vq[i].b,
             vq[i].ordy, vq[i].fl, vq[i].ack, vq[i].gnt);
      #1;
      chk({vq[i].nm, "_outs"}, 320'(main_outs()),
          320'({vq[i].flags, vq[i].tgt, vq[i].wrd, vq[i].wdat}));
      chk({vq[i].nm, "_cnt"}, 320'({perf_br_cnt, perf_taken_cnt}), 320'({vq[i].nbr, vq[i].ntk}));
      $display("vec %0d %s done", i, vq[i].nm);
      tick();
    end

    // ---- taken counter wrap: preload all-ones, then one taken branch
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    force dut.u_perf.taken_cnt_q = 32'hFFFF_FFFF;
    tick();
    release dut.u_perf.taken_cnt_q;
    #1;
    chk("wrap_preload", 320'(perf_taken_cnt), 320'(32'hFFFF_FFFF));
    set_in(1, BRU_B, 32'hA00, 32'h20, 0, 0, 0, 1, 0, 0, 0);
    tick();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("wrap_counts", 320'({perf_br_cnt, perf_taken_cnt}), 320'({32'd9, 32'd0}));
    chk("wrap_redir", 320'(main_outs()), 320'({F_REDK, 32'hA20, 5'd0, 32'd0}));
    $display("seq wrap done");

    // ---- reset asserted mid-REDIRECT
    tick();
    chk("rst_mid_pre", 320'(main_outs()), 320'({F_RED, 32'hA20, 5'd0, 32'd0}));
    resetn = 1'b0;
    #1;
    chk("rst_mid_low", 320'(all_outs()), 320'h0);
    tick();
    chk("rst_mid_edge", 320'(all_outs()), 320'h0);
    resetn = 1'b1;
    #1;
    chk("rst_mid_idle", 320'(main_outs()), 320'({F_IDLE, 32'h0, 5'd0, 32'd0}));
    chk("rst_mid_cnt", 320'({perf_br_cnt, perf_taken_cnt}), 320'h0);
    $display("seq reset_mid_redirect done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
